// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch PC sequencer slice.
// Holds the FSM state encoding and the default values of the
// reset PC and the epoch tag width used by fetch_pc_sequencer.
package fetch_pkg;

   // Fetch FSM states. The encoding is visible on state_o for debug.
   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      BUBBLE = 2'd2,
      HALT   = 2'd3
   } fetch_state_e;

   localparam logic [31:0] FETCH_RESET_PC   = 32'h0000_0000;
   localparam int          FETCH_EPOCH_BITS = 2;

endpackage

// File: rtl/fetch_pc_sequencer_redirect_arbiter.sv
// redirect_arbiter: combinational priority select between a trap
// redirect and a branch mispredict redirect.
// Ports:
//   trap_valid_i, trap_pc_i     - trap request and vector (highest priority)
//   mispredict_i, redirect_pc_i - mispredict request and corrected PC
//   redirect_valid_o            - some redirect is requested
//   target_o                    - winning target with bits [1:0] cleared
//   misaligned_o                - winning target had bits [1:0] != 0
module redirect_arbiter #(
   parameter int PC_WIDTH = 32
) (
   input  logic                trap_valid_i,
   input  logic [PC_WIDTH-1:0] trap_pc_i,
   input  logic                mispredict_i,
   input  logic [PC_WIDTH-1:0] redirect_pc_i,
   output logic                redirect_valid_o,
   output logic [PC_WIDTH-1:0] target_o,
   output logic                misaligned_o
);

   logic [PC_WIDTH-1:0] raw_target;

   // A trap always wins over a mispredict; the raw target is kept so the
   // misalignment of the chosen address can be reported.
   always_comb begin
      raw_target       = trap_valid_i ? trap_pc_i : redirect_pc_i;
      redirect_valid_o = trap_valid_i | mispredict_i;
      target_o         = {raw_target[PC_WIDTH-1:2], 2'b00};
      misaligned_o     = redirect_valid_o & (raw_target[1:0] != 2'b00);
   end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer: owns the fetch PC, steps it along the predictor's
// next-PC stream, and handles trap/mispredict redirects with a bubble,
// a one-cycle flush pulse and an epoch bump.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   pred_next_pc, pred_taken  - predictor lookup result for pc_fetch
//   mispredict, redirect_pc   - branch resolution redirect
//   trap_valid, trap_pc       - trap redirect (wins over mispredict)
//   halt_req                  - level request to stop fetching
//   fetch_ready               - downstream accepts the offered fetch
//   pc_fetch, fetch_valid     - current fetch address and its validity
//   fetch_pred_taken          - pred_taken qualified by fetch_valid
//   fetch_epoch               - epoch tag of the current fetch
//   flush, misaligned         - registered one-cycle pulses after a redirect
//   state_o                   - FSM state for debug
module fetch_pc_sequencer
   import fetch_pkg::*;
#(
   parameter int                  PC_WIDTH      = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC      = PC_WIDTH'(FETCH_RESET_PC),
   parameter int                  BUBBLE_CYCLES = 1,
   parameter int                  EPOCH_BITS    = FETCH_EPOCH_BITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [PC_WIDTH-1:0]   pred_next_pc,
   input  logic                  pred_taken,
   input  logic                  mispredict,
   input  logic [PC_WIDTH-1:0]   redirect_pc,
   input  logic                  trap_valid,
   input  logic [PC_WIDTH-1:0]   trap_pc,
   input  logic                  halt_req,
   input  logic                  fetch_ready,
   output logic [PC_WIDTH-1:0]   pc_fetch,
   output logic                  fetch_valid,
   output logic                  fetch_pred_taken,
   output logic [EPOCH_BITS-1:0] fetch_epoch,
   output logic                  flush,
   output logic                  misaligned,
   output logic [1:0]            state_o
);

   fetch_state_e          state_q;
   logic [PC_WIDTH-1:0]   pc_q;
   logic [EPOCH_BITS-1:0] epoch_q, epoch_d;
   logic [2:0]            bubble_cnt_q, bubble_cnt_d;
   logic                  flush_q;
   logic                  misaligned_q;

   logic                  arb_valid;
   logic [PC_WIDTH-1:0]   arb_target;
   logic                  arb_misaligned;
   logic                  redirect;

   redirect_arbiter #(
      .PC_WIDTH (PC_WIDTH)
   ) u_arbiter (
      .trap_valid_i     (trap_valid),
      .trap_pc_i        (trap_pc),
      .mispredict_i     (mispredict),
      .redirect_pc_i    (redirect_pc),
      .redirect_valid_o (arb_valid),
      .target_o         (arb_target),
      .misaligned_o     (arb_misaligned)
   );

   // Redirects are meaningless before the first fetch, so BOOT masks them.
   assign redirect     = arb_valid & (state_q != BOOT);
   assign epoch_d      = epoch_q + EPOCH_BITS'(1);
   assign bubble_cnt_d = bubble_cnt_q - 3'd1;

   // Single FSM: PC register, epoch, bubble counter and the redirect pulses.
   // A redirect beats both fetch_ready and halt_req; in HALT it updates the
   // PC and epoch but leaves the machine halted.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= BOOT;
         pc_q         <= RESET_PC;
         epoch_q      <= '0;
         bubble_cnt_q <= '0;
         flush_q      <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         flush_q      <= 1'b0;
         misaligned_q <= 1'b0;
         if (redirect) begin
            pc_q         <= arb_target;
            epoch_q      <= epoch_d;
            flush_q      <= 1'b1;
            misaligned_q <= arb_misaligned;
            if (state_q != HALT) begin
               state_q      <= BUBBLE;
               bubble_cnt_q <= 3'(BUBBLE_CYCLES - 1);
            end
         end else begin
            case (state_q)
               BOOT: state_q <= halt_req ? HALT : RUN;
               RUN: begin
                  // Only halt on an accepted fetch so an offer is never withdrawn.
                  if (fetch_ready) begin
                     pc_q <= pred_next_pc;
                     if (halt_req) state_q <= HALT;
                  end
               end
               BUBBLE: begin
                  if (bubble_cnt_q == 3'd0) state_q <= halt_req ? HALT : RUN;
                  else                      bubble_cnt_q <= bubble_cnt_d;
               end
               HALT: if (!halt_req) state_q <= RUN;
               default: state_q <= BOOT;
            endcase
         end
      end
   end

   assign pc_fetch         = pc_q;
   assign fetch_valid      = (state_q == RUN);
   assign fetch_pred_taken = pred_taken & (state_q == RUN);
   assign fetch_epoch      = epoch_q;
   assign flush            = flush_q;
   assign misaligned       = misaligned_q;
   assign state_o          = state_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Table-driven bench for fetch_pc_sequencer with default parameters
// (RESET_PC=0, BUBBLE_CYCLES=1, EPOCH_BITS=2). Each row gives the inputs
// held across one rising edge and the outputs expected just after it.
module tb_fetch_pc_sequencer;

   typedef struct {
      string       name;
      logic        rst;
      logic [31:0] npc;
      logic        ptk;
      logic        mp;
      logic [31:0] rpc;
      logic        tv;
      logic [31:0] tpc;
      logic        halt;
      logic        rdy;
      logic [31:0] exp_pc;
      logic        exp_valid;
      logic        exp_ptk;
      logic [1:0]  exp_epoch;
      logic        exp_flush;
      logic        exp_mis;
      logic [1:0]  exp_state;
   } vec_t;

   localparam logic [1:0] S_BOOT = 2'd0, S_RUN = 2'd1, S_BUB = 2'd2, S_HALT = 2'd3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pred_next_pc = '0;
   logic        pred_taken = 1'b0;
   logic        mispredict = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        trap_valid = 1'b0;
   logic [31:0] trap_pc = '0;
   logic        halt_req = 1'b0;
   logic        fetch_ready = 1'b0;
   logic [31:0] pc_fetch;
   logic        fetch_valid;
   logic        fetch_pred_taken;
   logic [1:0]  fetch_epoch;
   logic        flush;
   logic        misaligned;
   logic [1:0]  state_o;

   int vectors = 0;
   int miscompares = 0;
   vec_t tbl[$];

   fetch_pc_sequencer dut (
      .clk              (clk),
      .rst              (rst),
      .pred_next_pc     (pred_next_pc),
      .pred_taken       (pred_taken),
      .mispredict       (mispredict),
      .redirect_pc      (redirect_pc),
      .trap_valid       (trap_valid),
      .trap_pc          (trap_pc),
      .halt_req         (halt_req),
      .fetch_ready      (fetch_ready),
      .pc_fetch         (pc_fetch),
      .fetch_valid      (fetch_valid),
      .fetch_pred_taken (fetch_pred_taken),
      .fetch_epoch      (fetch_epoch),
      .flush            (flush),
      .misaligned       (misaligned),
      .state_o          (state_o)
   );

   always #5 clk = ~clk;

   // Append one row; the expected taken flag is pred_taken gated by valid.
   function automatic void add(string nm, logic r, logic [31:0] npc, logic ptk,
                               logic mp, logic [31:0] rpc, logic tv, logic [31:0] tpc,
                               logic h, logic rdy, logic [31:0] epc, logic ev,
                               logic [1:0] eep, logic efl, logic emis, logic [1:0] est);
      vec_t v;
      v.name = nm; v.rst = r; v.npc = npc; v.ptk = ptk; v.mp = mp; v.rpc = rpc;
      v.tv = tv; v.tpc = tpc; v.halt = h; v.rdy = rdy;
      v.exp_pc = epc; v.exp_valid = ev; v.exp_ptk = ptk & ev; v.exp_epoch = eep;
      v.exp_flush = efl; v.exp_mis = emis; v.exp_state = est;
      tbl.push_back(v);
   endfunction

   task automatic applyStimulus(input vec_t v);
      rst          = v.rst;
      pred_next_pc = v.npc;
      pred_taken   = v.ptk;
      mispredict   = v.mp;
      redirect_pc  = v.rpc;
      trap_valid   = v.tv;
      trap_pc      = v.tpc;
      halt_req     = v.halt;
      fetch_ready  = v.rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input vec_t v);
      vectors++;
      if (pc_fetch !== v.exp_pc || fetch_valid !== v.exp_valid ||
          fetch_pred_taken !== v.exp_ptk || fetch_epoch !== v.exp_epoch ||
          flush !== v.exp_flush || misaligned !== v.exp_mis || state_o !== v.exp_state) begin
         miscompares++;
         $display("[TB] FAIL %s: got pc=%h v=%b tk=%b ep=%0d fl=%b mis=%b st=%0d, expected pc=%h v=%b tk=%b ep=%0d fl=%b mis=%b st=%0d",
                  v.name, pc_fetch, fetch_valid, fetch_pred_taken, fetch_epoch, flush,
                  misaligned, state_o, v.exp_pc, v.exp_valid, v.exp_ptk, v.exp_epoch,
                  v.exp_flush, v.exp_mis, v.exp_state);
      end
   endtask

   task automatic checkValue(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   initial begin
      int cycles;
      //    name           rst npc       tk mp rpc      tv tpc       h rdy  exp_pc   v ep fl mis state
      add("reset0",       1, 32'h4,    0, 0, 32'h0,   0, 32'h0,    0, 0, 32'h0,   0, 0, 0, 0, S_BOOT);
      add("reset1",       1, 32'h4,    0, 1, 32'h50,  1, 32'h60,   0, 1, 32'h0,   0, 0, 0, 0, S_BOOT);
      add("reset2",       1, 32'h4,    0, 0, 32'h0,   0, 32'h0,    0, 0, 32'h0,   0, 0, 0, 0, S_BOOT);
      add("boot_to_run",  0, 32'h4,    0, 0, 32'h0,   0, 32'h0,    0, 1, 32'h0,   1, 0, 0, 0, S_RUN);
      add("seq_4",        0, 32'h4,    0, 0, 32'h0,   0, 32'h0,    0, 1, 32'h4,   1, 0, 0, 0, S_RUN);
      add("seq_8",        0, 32'h8,    0, 0, 32'h0,   0, 32'h0,    0, 1, 32'h8,   1, 0, 0, 0, S_RUN);
      add("stall_a",      0, 32'hC,    0, 0, 32'h0,   0, 32'h0,    0, 0, 32'h8,   1, 0, 0, 0, S_RUN);
      add("stall_b",      0, 32'hC,    0, 0, 32'h0,   0, 32'h0,    0, 0, 32'h8,   1, 0, 0, 0, S_RUN);
      add("stall_c",      0, 32'hC,    0, 0, 32'h0,   0, 32'h0,    0, 0, 32'h8,   1, 0, 0, 0, S_RUN);
      add("seq_C",        0, 32'hC,    1, 0, 32'h0,   0, 32'h0,    0, 1, 32'hC,   1, 0, 0, 0, S_RUN);
      add("seq_10",       0, 32'h10,   1, 0, 32'h0,   0, 32'h0,    0, 1, 32'h10,  1, 0, 0, 0, S_RUN);
      add("mispredict",   0, 32'h14,   1, 1, 32'h200, 0, 32'h0,    0, 1, 32'h200, 0, 1, 1, 0, S_BUB);
      add("bubble_done",  0, 32'h204,  0, 0, 32'h0,   0, 32'h0,    0, 1, 32'h200, 1, 1, 0, 0, S_RUN);
      add("trap_wins",    0, 32'h204,  0, 1, 32'h300, 1, 32'h80,   0, 1, 32'h80,  0, 2, 1, 0, S_BUB);
      add("after_trap",   0, 32'h84,   0, 0, 32'h0,   0, 32'h0,    0, 0, 32'h80,  1, 2, 0, 0, S_RUN);
      add("misalign",     0, 32'h84,   0, 1, 32'h103, 0, 32'h0,    0, 0, 32'h100, 0, 3, 1, 1, S_BUB);
      add("redir_wrap",   0, 32'h104,  0, 1, 32'h200, 0, 32'h0,    0, 0, 32'h200, 0, 0, 1, 0, S_BUB);
      add("trap_mis",     0, 32'h204,  0, 0, 32'h0,   1, 32'h302,  0, 0, 32'h300, 0, 1, 1, 1, S_BUB);
      add("redir_4th",    0, 32'h304,  0, 1, 32'h10,  0, 32'h0,    0, 0, 32'h10,  0, 2, 1, 0, S_BUB);
      add("run_again",    0, 32'h14,   0, 0, 32'h0,   0, 32'h0,    0, 0, 32'h10,  1, 2, 0, 0, S_RUN);
      add("halt_wait_a",  0, 32'h14,   0, 0, 32'h0,   0, 32'h0,    1, 0, 32'h10,  1, 2, 0, 0, S_RUN);
      add("halt_wait_b",  0, 32'h14,   0, 0, 32'h0,   0, 32'h0,    1, 0, 32'h10,  1, 2, 0, 0, S_RUN);
      add("halt_enter",   0, 32'h14,   1, 0, 32'h0,   0, 32'h0,    1, 1, 32'h14,  0, 2, 0, 0, S_HALT);
      add("halt_redir",   0, 32'h18,   0, 1, 32'h400, 0, 32'h0,    1, 1, 32'h400, 0, 3, 1, 0, S_HALT);
      add("halt_hold",    0, 32'h404,  0, 0, 32'h0,   0, 32'h0,    1, 1, 32'h400, 0, 3, 0, 0, S_HALT);
      add("halt_exit",    0, 32'h999,  0, 0, 32'h0,   0, 32'h0,    0, 1, 32'h400, 1, 3, 0, 0, S_RUN);
      add("halt_and_mp",  0, 32'h404,  0, 1, 32'h500, 0, 32'h0,    1, 1, 32'h500, 0, 0, 1, 0, S_BUB);
      add("bubble_halt",  0, 32'h504,  0, 0, 32'h0,   0, 32'h0,    1, 1, 32'h500, 0, 0, 0, 0, S_HALT);
      add("halt_release", 0, 32'h504,  0, 0, 32'h0,   0, 32'h0,    0, 0, 32'h500, 1, 0, 0, 0, S_RUN);
      add("pre_reset_mp", 0, 32'h504,  0, 1, 32'h600, 0, 32'h0,    0, 0, 32'h600, 0, 1, 1, 0, S_BUB);
      add("reset_mid",    1, 32'h604,  0, 1, 32'h700, 0, 32'h0,    0, 0, 32'h0,   0, 0, 0, 0, S_BOOT);
      add("boot_halt",    0, 32'h4,    0, 0, 32'h0,   1, 32'h80,   1, 1, 32'h0,   0, 0, 0, 0, S_HALT);
      add("boot_unhalt",  0, 32'h4,    0, 0, 32'h0,   0, 32'h0,    0, 1, 32'h0,   1, 0, 0, 0, S_RUN);

      foreach (tbl[i]) begin
         applyStimulus(tbl[i]);
         checkOutput(tbl[i]);
      end

      // Hand sequence: one-cycle mispredict, then measure how long until
      // fetch_valid returns (target plus flush at t+1, valid at t+2).
      fetch_ready  = 1'b0;
      mispredict   = 1'b1;
      redirect_pc  = 32'h700;
      @(posedge clk);
      #1;
      mispredict   = 1'b0;
      checkValue("lat_flush", {31'd0, flush}, 32'd1);
      checkValue("lat_pc", pc_fetch, 32'h700);
      cycles = 1;
      while (!fetch_valid && cycles < 10) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      checkValue("lat_valid_cycles", cycles, 32'd2);
      checkValue("lat_epoch", {30'd0, fetch_epoch}, 32'd1);
      checkValue("lat_flush_gone", {31'd0, flush}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_pc_sequencer.md
Name: fetch_pc_sequencer

Overview:
Fetch-stage controller that owns the fetch PC register and sequences the branch predictor every cycle. It drives the predictor's fetch-PC lookup and advances to the predicted next PC when downstream accepts the fetch. It arbitrates redirect sources (trap over mispredict over prediction), inserts redirect bubbles and emits a flush pulse plus an epoch tag so younger wrong-path instructions can be discarded.

Parameters:
PC_WIDTH, 32, width of all PCs
RESET_PC, 32'h0000_0000, first fetch address after reset
BUBBLE_CYCLES, 1, fetch_valid-low cycles after any redirect (legal range 1..7)
EPOCH_BITS, 2, width of the epoch tag (wraps)

Ports:
clk  in  1  clock; all state on the rising edge
rst  in  1  synchronous active-high reset
pred_next_pc  in  PC_WIDTH  predictor's next PC for pc_fetch (taken target or pc_fetch+4)
pred_taken  in  1  predictor's taken flag for pc_fetch
mispredict  in  1  branch resolution disagreed with the prediction
redirect_pc  in  PC_WIDTH  correct PC on mispredict
trap_valid  in  1  exception/trap redirect request
trap_pc  in  PC_WIDTH  trap vector
halt_req  in  1  level request to stop fetching
fetch_ready  in  1  downstream accepts the current fetch
pc_fetch  out  PC_WIDTH  current fetch PC, fed to the predictor and imem
fetch_valid  out  1  pc_fetch is a valid fetch
fetch_pred_taken  out  1  pred_taken qualified by fetch_valid
fetch_epoch  out  EPOCH_BITS  epoch of the current fetch
flush  out  1  one-cycle pulse; kill all in-flight fetch/decode state
misaligned  out  1  one-cycle pulse; the accepted redirect target had bits [1:0] != 0
state_o  out  2  FSM state, debug only

Behaviour:
- Reset values, asserted whenever rst=1 at a clock edge and taking priority over everything: state=BOOT, pc_fetch=RESET_PC, fetch_valid=0, fetch_epoch=0, flush=0, misaligned=0, bubble counter=0. A reset mid-bubble or mid-halt discards all pending work.
- States (encoding in the package): BOOT=0, RUN=1, BUBBLE=2, HALT=3.
- BOOT: fetch_valid=0. Moves to RUN at the next edge unless halt_req=1, in which case it moves to HALT. The first valid fetch appears 2 cycles after rst falls.
- RUN: fetch_valid=1, with fetch_valid and fetch_pred_taken driven combinationally from state. On fetch_ready=1, pc_fetch <= pred_next_pc. On fetch_ready=0, pc_fetch is held and the prediction is re-looked-up unchanged.
- Redirect arbitration, evaluated in every state except BOOT, trap_valid over mispredict:
  - Winning target: trap_pc or redirect_pc.
  - pc_fetch <= target with bits [1:0] forced to 0.
  - fetch_epoch <= fetch_epoch+1, modulo 2^EPOCH_BITS.
  - flush=1 for exactly the next cycle (registered).
  - misaligned=1 for the next cycle if target[1:0] != 0.
  - A redirect overrides fetch_ready and pred_next_pc in the same cycle.
- After a redirect in RUN or BUBBLE: state <= BUBBLE, counter <= BUBBLE_CYCLES-1. A redirect during BUBBLE restarts the count.
- BUBBLE: fetch_valid=0. Counter decrements each cycle. At counter==0 with no redirect, state <= RUN, or HALT if halt_req=1.
- HALT:
  - Entered from RUN when halt_req=1, only on a cycle with fetch_ready=1 or fetch_valid=0, so an offered fetch is never withdrawn.
  - fetch_valid=0; pc_fetch held.
  - A redirect in HALT updates pc_fetch, epoch, flush and misaligned, but the state stays HALT.
  - halt_req=0 -> RUN at the next edge.
- Simultaneous halt_req and redirect in RUN: the redirect is taken and the state goes to BUBBLE; the halt is honoured when the bubble expires.
- mispredict and trap_valid are ignored during BOOT.
- Next-PC arithmetic is done by the predictor; this block adds nothing and all PCs are PC_WIDTH wide, so there is no wrap handling beyond the natural PC_WIDTH overflow inside the predictor.
- Latency: a redirect at cycle t gives pc_fetch=target and flush=1 at t+1, and fetch_valid=1 at t+1+BUBBLE_CYCLES.

Decomposition:
- Shared package fetch_pkg holds:
  - FSM state localparams BOOT/RUN/BUBBLE/HALT;
  - RESET_PC default;
  - the EPOCH_BITS default.
- One natural sub-module: redirect_arbiter, a combinational priority select of trap/mispredict producing redirect_valid, the aligned target and the misaligned flag. Everything else (FSM, counter, PC register) stays in fetch_pc_sequencer.

Test Plan:
- Reset: rst high 3 cycles, then low -> pc_fetch=0, fetch_valid=0 in the first cycle after release, fetch_valid=1 with pc_fetch=0 in the second; epoch=0.
- Sequential fetch: pred_next_pc=pc+4, fetch_ready=1 for 4 cycles -> pc_fetch 0,4,8,C. With fetch_ready=0 at pc=8 for 3 cycles -> pc_fetch holds 8, fetch_valid stays 1.
- Mispredict at pc=0x10 with redirect_pc=0x200, BUBBLE_CYCLES=1 -> next cycle pc_fetch=0x200, flush=1, epoch 0->1, fetch_valid=0. The cycle after: fetch_valid=1.
- Simultaneous trap_pc=0x80 and mispredict redirect_pc=0x300 -> pc_fetch=0x80, a single flush pulse, epoch increments by exactly 1.
- Misaligned redirect_pc=0x103 -> pc_fetch=0x100, misaligned=1 for 1 cycle. Four consecutive redirects -> epoch 1,2,3,0 (wrap).
- Halt: halt_req=1 while fetch_ready=0 -> stays RUN until fetch_ready=1, then HALT with fetch_valid=0. Mispredict to 0x400 in HALT -> pc_fetch=0x400, still HALT. halt_req=0 -> RUN with pc_fetch=0x400, fetch_valid=1.
